// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU for a 5-stage RISC-V pipeline.
// Single-cycle ops produce a registered result one edge after acceptance.
// MUL runs as an XLEN-step shift-add sequence.
// Optional feature macro ALU_DIV_EN adds an iterative restoring divider
// for DIVU/REMU. Without the macro those opcodes complete in one cycle
// with a zero result.
module alu_seq #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in1,
   input  logic [XLEN-1:0] in2,
   input  logic [XLEN-1:0] pc,
   input  logic [3:0]      ctrl,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_out,
   output logic            branch_taken,
   output logic            busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_XOR   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_AND   = 4'h4;
   localparam logic [3:0] OP_SLL   = 4'h5;
   localparam logic [3:0] OP_SRL   = 4'h6;
   localparam logic [3:0] OP_BEQ   = 4'h7;
   localparam logic [3:0] OP_BNE   = 4'h8;
   localparam logic [3:0] OP_SLT   = 4'h9;
   localparam logic [3:0] OP_AUIPC = 4'hA;
   localparam logic [3:0] OP_SLTU  = 4'hB;
   localparam logic [3:0] OP_SRA   = 4'hC;
   localparam logic [3:0] OP_MUL   = 4'hD;
   localparam logic [3:0] OP_DIVU  = 4'hE;
   localparam logic [3:0] OP_REMU  = 4'hF;

   // Iteration counter runs XLEN-1 down to 0, giving exactly XLEN steps.
   localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(XLEN - 1);
   localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
   localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
   localparam logic [XLEN-1:0]    X_ZERO   = {XLEN{1'b0}};

   state_t              state_r;
   state_t              state_nx_s;
   logic                accept_s;
   logic                iter_op_s;
   logic [XLEN-1:0]     res_s;
   logic                br_s;
   logic [SHAMT_W-1:0]  shamt_s;

   logic [SHAMT_W-1:0]  cnt_r;
   logic [XLEN-1:0]     a_r;      // MUL: multiplicand; DIV: dividend -> quotient
   logic [XLEN-1:0]     b_r;      // MUL: multiplier;   DIV: divisor
   logic [XLEN-1:0]     acc_r;    // MUL: product;      DIV: partial remainder
   logic                take_acc_r;
   logic                out_valid_r;
   logic [XLEN-1:0]     alu_out_r;
   logic                branch_r;
   logic                busy_r;

`ifdef ALU_DIV_EN
   logic [XLEN:0]       div_shift_s;
   logic [XLEN:0]       div_trial_s;
`endif

   assign in_ready     = (state_r == IDLE) && (!out_valid_r || out_ready);
   assign accept_s     = in_valid && in_ready;
   assign shamt_s      = in2[SHAMT_W-1:0];
   assign out_valid    = out_valid_r;
   assign alu_out      = alu_out_r;
   assign branch_taken = branch_r;
   assign busy         = busy_r;

   // Classify the incoming opcode as iterative (multi-cycle) or single-cycle.
   always_comb begin
      iter_op_s = 1'b0;
      if (ctrl == OP_MUL) begin
         iter_op_s = 1'b1;
      end
`ifdef ALU_DIV_EN
      else if ((ctrl == OP_DIVU) || (ctrl == OP_REMU)) begin
         iter_op_s = 1'b1;
      end
`endif
      else begin
         iter_op_s = 1'b0;
      end
   end

   // Single-cycle result and branch outcome computed from the live operands.
   always_comb begin
      res_s = X_ZERO;
      br_s  = 1'b0;
      case (ctrl)
         OP_ADD:   res_s = in1 + in2;
         OP_SUB:   res_s = in1 - in2;
         OP_XOR:   res_s = in1 ^ in2;
         OP_OR:    res_s = in1 | in2;
         OP_AND:   res_s = in1 & in2;
         OP_SLL:   res_s = in1 << shamt_s;
         OP_SRL:   res_s = in1 >> shamt_s;
         OP_BEQ:   br_s  = (in1 == in2);
         OP_BNE:   br_s  = (in1 != in2);
         OP_SLT:   res_s = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
         OP_AUIPC: res_s = pc + (in2 << 32'd12);
         OP_SLTU:  res_s = {{(XLEN-1){1'b0}}, (in1 < in2)};
         OP_SRA:   res_s = $signed(in1) >>> shamt_s;
         OP_MUL:   res_s = X_ZERO;
         OP_DIVU:  res_s = X_ZERO;
         OP_REMU:  res_s = X_ZERO;
         default:  res_s = X_ZERO;
      endcase
   end

`ifdef ALU_DIV_EN
   // One restoring-division step: shift in the next dividend bit and try to subtract.
   always_comb begin
      div_shift_s = {acc_r, a_r[XLEN-1]};
      div_trial_s = div_shift_s - {1'b0, b_r};
   end
`endif

   // Next-state logic for the sequencing FSM.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (ctrl == OP_MUL) begin
                  state_nx_s = MUL;
               end
`ifdef ALU_DIV_EN
               else if ((ctrl == OP_DIVU) || (ctrl == OP_REMU)) begin
                  state_nx_s = DIV;
               end
`endif
               else begin
                  state_nx_s = IDLE;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         MUL: begin
            if (cnt_r == CNT_ZERO) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = MUL;
            end
         end
         DIV: begin
`ifdef ALU_DIV_EN
            if (cnt_r == CNT_ZERO) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = DIV;
            end
`else
            state_nx_s = IDLE;
`endif
         end
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // State register; reset aborts any iteration in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Busy flag, registered from the next state so it tracks the FSM exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
      end else begin
         busy_r <= (state_nx_s != IDLE);
      end
   end

   // Operand latching, iterative datapath and output register with hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= CNT_ZERO;
         a_r         <= X_ZERO;
         b_r         <= X_ZERO;
         acc_r       <= X_ZERO;
         take_acc_r  <= 1'b0;
         out_valid_r <= 1'b0;
         alu_out_r   <= X_ZERO;
         branch_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  a_r        <= in1;
                  b_r        <= in2;
                  acc_r      <= X_ZERO;
                  cnt_r      <= CNT_LAST;
                  take_acc_r <= (ctrl != OP_DIVU);
                  if (iter_op_s) begin
                     // Any previous result is being consumed this edge.
                     out_valid_r <= 1'b0;
                  end else begin
                     alu_out_r   <= res_s;
                     branch_r    <= br_s;
                     out_valid_r <= 1'b1;
                  end
               end else if (out_ready) begin
                  out_valid_r <= 1'b0;
               end else begin
                  out_valid_r <= out_valid_r;
               end
            end
            MUL: begin
               if (b_r[0]) begin
                  acc_r <= acc_r + a_r;
               end else begin
                  acc_r <= acc_r;
               end
               a_r   <= {a_r[XLEN-2:0], 1'b0};
               b_r   <= {1'b0, b_r[XLEN-1:1]};
               cnt_r <= cnt_r - CNT_ONE;
            end
            DIV: begin
`ifdef ALU_DIV_EN
               // A zero divisor never underflows, giving all-ones quotient and remainder = dividend.
               if (div_trial_s[XLEN]) begin
                  acc_r <= div_shift_s[XLEN-1:0];
                  a_r   <= {a_r[XLEN-2:0], 1'b0};
               end else begin
                  acc_r <= div_trial_s[XLEN-1:0];
                  a_r   <= {a_r[XLEN-2:0], 1'b1};
               end
               cnt_r <= cnt_r - CNT_ONE;
`else
               cnt_r <= CNT_ZERO;
`endif
            end
            DONE: begin
               alu_out_r   <= take_acc_r ? acc_r : a_r;
               branch_r    <= 1'b0;
               out_valid_r <= 1'b1;
            end
            default: begin
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed steps with a result scoreboard.
// Division checks are included when ALU_DIV_EN is defined.
module tb_alu_seq;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in1;
   logic [XLEN-1:0] in2;
   logic [XLEN-1:0] pc;
   logic [3:0]      ctrl;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_out;
   logic            branch_taken;
   logic            busy;

   int total = 0;
   int bad   = 0;
   logic [XLEN:0] exp_q[$];

   alu_seq #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .pc(pc), .ctrl(ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
      .branch_taken(branch_taken), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Scoreboard: compare every delivered result against the oldest expectation.
   always @(negedge clk) begin
      logic [XLEN:0] e;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_result got=%08h exp=none", alu_out);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("result", alu_out, e[XLEN-1:0]);
            chk("branch", {31'd0, branch_taken}, {31'd0, e[XLEN]});
         end
      end
   end

   // Present one op, wait (bounded) for acceptance, optionally queue its expectation.
   task automatic do_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] p, input logic [XLEN-1:0] er, input logic eb,
                        input bit push, input bit iter);
      int n;
      if (push) exp_q.push_back({eb, er});
      ctrl = op; in1 = a; in2 = b; pc = p; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!iter) chk("lat1_valid", {31'd0, out_valid}, 32'd1);
   endtask

   // Iterative op: busy/in_ready/out_valid over XLEN+1 edges, then result valid.
   task automatic iter_check(input string tag);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < XLEN + 1; k++) begin
         if (!(busy === 1'b1 && in_ready === 1'b0 && out_valid === 1'b0)) ok = 1'b0;
         @(posedge clk); #1;
      end
      chk({tag, "_busy"}, {31'd0, ok}, 32'd1);
      chk({tag, "_done"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   // Directed test sequence.
   initial begin
      logic seen;
      int   n;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in1 = 32'd0; in2 = 32'd0; pc = 32'd0; ctrl = 4'h0;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_alu_out", alu_out, 32'd0);
      chk("rst_branch", {31'd0, branch_taken}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // Single-cycle ops, back to back.
      do_op(4'h0, 32'hFFFFFFFF, 32'h1,        32'h0, 32'h00000000, 1'b0, 1'b1, 1'b0);
      do_op(4'h1, 32'h0,        32'h1,        32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
      do_op(4'hC, 32'h80000000, 32'h24,       32'h0, 32'hF8000000, 1'b0, 1'b1, 1'b0);
      do_op(4'h5, 32'h1,        32'd31,       32'h0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      do_op(4'h7, 32'd5,        32'd5,        32'h0, 32'h0,        1'b1, 1'b1, 1'b0);
      do_op(4'h8, 32'd5,        32'd5,        32'h0, 32'h0,        1'b0, 1'b1, 1'b0);
      do_op(4'h8, 32'd1,        32'd2,        32'h0, 32'h0,        1'b1, 1'b1, 1'b0);
      do_op(4'h9, 32'hFFFFFFFF, 32'h1,        32'h0, 32'h1,        1'b0, 1'b1, 1'b0);
      do_op(4'hB, 32'hFFFFFFFF, 32'h1,        32'h0, 32'h0,        1'b0, 1'b1, 1'b0);
      do_op(4'h2, 32'hA5A5A5A5, 32'hFFFF0000, 32'h0, 32'h5A5AA5A5, 1'b0, 1'b1, 1'b0);
      do_op(4'h3, 32'h0F0F0000, 32'h000000F0, 32'h0, 32'h0F0F00F0, 1'b0, 1'b1, 1'b0);
      do_op(4'h4, 32'h12345678, 32'h0000FFFF, 32'h0, 32'h00005678, 1'b0, 1'b1, 1'b0);
      do_op(4'h6, 32'h80000000, 32'd4,        32'h0, 32'h08000000, 1'b0, 1'b1, 1'b0);
      do_op(4'hA, 32'h0,        32'h00012345, 32'h1000, 32'h12346000, 1'b0, 1'b1, 1'b0);
      do_op(4'h7, 32'd5,        32'd6,        32'h0, 32'h0,        1'b0, 1'b1, 1'b0);

      // Iterative multiply.
      do_op(4'hD, 32'h00010001, 32'h00010001, 32'h0, 32'h00020001, 1'b0, 1'b1, 1'b1);
      iter_check("mul1");
      do_op(4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000001, 1'b0, 1'b1, 1'b1);
      iter_check("mul2");

`ifdef ALU_DIV_EN
      do_op(4'hE, 32'd100, 32'd7, 32'h0, 32'd14,        1'b0, 1'b1, 1'b1);
      iter_check("divu");
      do_op(4'hF, 32'd100, 32'd7, 32'h0, 32'd2,         1'b0, 1'b1, 1'b1);
      iter_check("remu");
      do_op(4'hE, 32'd5,   32'd0, 32'h0, 32'hFFFFFFFF,  1'b0, 1'b1, 1'b1);
      iter_check("divu0");
      do_op(4'hF, 32'd5,   32'd0, 32'h0, 32'd5,         1'b0, 1'b1, 1'b1);
      iter_check("remu0");
`else
      do_op(4'hE, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      do_op(4'hF, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
`endif

      // Backpressure: ADD 2+3 held for 5 cycles with out_ready low.
      @(posedge clk); #1;
      out_ready = 1'b0;
      do_op(4'h0, 32'd2, 32'd3, 32'h0, 32'd5, 1'b0, 1'b1, 1'b0);
      in_valid = 1'b1; ctrl = 4'h0; in1 = 32'd9; in2 = 32'd9;
      for (int k = 0; k < 5; k++) begin
         chk("hold_value", alu_out, 32'd5);
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      do_op(4'h0, 32'd7, 32'd8, 32'h0, 32'd15, 1'b0, 1'b1, 1'b0);

      // Reset pulse mid-iteration aborts the op without a result.
      @(posedge clk); #1;
`ifdef ALU_DIV_EN
      do_op(4'hE, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
`else
      do_op(4'hD, 32'd3, 32'd4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
`endif
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #3;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      #4 rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      chk("abort_no_valid", {31'd0, seen}, 32'd0);

      // Post-reset sanity op.
      do_op(4'h0, 32'd40, 32'd2, 32'h0, 32'd42, 1'b0, 1'b1, 1'b0);

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
